// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer
// Receive-side splitter for a four-slot time-division-multiplexed stream.
// Samples are collected slot by slot (a, b, c, d) into a capture buffer while
// a small IDLE/RUN FSM tracks frame alignment from frame_sync. When the
// slot-3 sample is accepted, the whole frame is transferred to the output
// registers in one edge, with a one-cycle out_valid strobe. Sync
// misalignment is reported by a one-cycle frame_err strobe.
// Every output is driven from a register. No input reaches an output
// without passing through a flop.

module tdm_demultiplexer #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [WIDTH-1:0]     d,
    output logic                 out_valid,
    output logic [1:0]           sel,
    output logic                 locked,
    output logic                 frame_err,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    // FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Slot indices
    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    // State and capture registers
    logic [0:0]           state_r;
    logic [1:0]           sel_r;
    logic [WIDTH-1:0]     cap0_r;
    logic [WIDTH-1:0]     cap1_r;
    logic [WIDTH-1:0]     cap2_r;

    // Output registers
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     c_r;
    logic [WIDTH-1:0]     d_r;
    logic                 out_valid_r;
    logic                 frame_err_r;
    logic [CNT_WIDTH-1:0] frame_cnt_r;

    // Next-state / decoded control
    logic [0:0]           state_nxt_s;
    logic [1:0]           sel_nxt_s;
    logic                 wr_en_s;
    logic [1:0]           wr_slot_s;
    logic                 complete_s;
    logic                 err_s;

    // Decide what the current cycle does: capture, complete, flag an error or ignore.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        wr_en_s     = 1'b0;
        wr_slot_s   = sel_r;
        complete_s  = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                // Only a sync-qualified sample can start a frame.
                if (din_valid && frame_sync) begin
                    wr_en_s     = 1'b1;
                    wr_slot_s   = SLOT0;
                    sel_nxt_s   = SLOT1;
                    state_nxt_s = RUN;
                end else begin
                    sel_nxt_s   = SLOT0;
                end
            end
            RUN: begin
                if (!din_valid) begin
                    // Stall: hold everything.
                    state_nxt_s = RUN;
                end else if (frame_sync) begin
                    // A sync always restarts at slot 0; early sync drops the
                    // partial frame and reports misalignment.
                    if (sel_r != SLOT0) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = 1'b0;
                    end
                    wr_en_s   = 1'b1;
                    wr_slot_s = SLOT0;
                    sel_nxt_s = SLOT1;
                end else if (sel_r == SLOT0) begin
                    // Slot 0 without sync: alignment lost, sample dropped.
                    err_s       = 1'b1;
                    sel_nxt_s   = SLOT0;
                    state_nxt_s = IDLE;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_slot_s = sel_r;
                    sel_nxt_s = sel_r + 2'd1;
                    if (sel_r == SLOT3) begin
                        complete_s = 1'b1;
                    end else begin
                        complete_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                sel_nxt_s   = SLOT0;
            end
        endcase
    end

    // FSM state and slot pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sel_r   <= SLOT0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    // Capture buffer for slots 0..2; slot 3 bypasses straight to d.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap0_r <= {WIDTH{1'b0}};
            cap1_r <= {WIDTH{1'b0}};
            cap2_r <= {WIDTH{1'b0}};
        end else if (wr_en_s) begin
            case (wr_slot_s)
                SLOT0:   cap0_r <= din;
                SLOT1:   cap1_r <= din;
                SLOT2:   cap2_r <= din;
                default: cap2_r <= cap2_r;
            endcase
        end
    end

    // Frame output registers, loaded all at once on frame completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
            c_r <= {WIDTH{1'b0}};
            d_r <= {WIDTH{1'b0}};
        end else if (complete_s) begin
            a_r <= cap0_r;
            b_r <= cap1_r;
            c_r <= cap2_r;
            d_r <= din;
        end
    end

    // One-cycle status strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            out_valid_r <= complete_s;
            frame_err_r <= err_s;
        end
    end

    // Completed-frame counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (complete_s) begin
            frame_cnt_r <= frame_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign a         = a_r;
    assign b         = b_r;
    assign c         = c_r;
    assign d         = d_r;
    assign out_valid = out_valid_r;
    assign frame_err = frame_err_r;
    assign frame_cnt = frame_cnt_r;
    assign sel       = sel_r;
    assign locked    = (state_r == RUN);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Testbench for tdm_demultiplexer: directed scenarios with literal
// expectations, an exhaustive 64-frame sweep, counter wrap and a randomized
// phase, all checked every cycle against a queue-based frame model.

module tb_tdm_demultiplexer;

    localparam int WIDTH     = 1;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [WIDTH-1:0]     din = '0;
    logic                 din_valid = 1'b0;
    logic                 frame_sync = 1'b0;
    logic [WIDTH-1:0]     a, b, c, d;
    logic                 out_valid;
    logic [1:0]           sel;
    logic                 locked;
    logic                 frame_err;
    logic [CNT_WIDTH-1:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    tdm_demultiplexer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .a(a), .b(b), .c(c), .d(d),
        .out_valid(out_valid), .sel(sel), .locked(locked),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the current frame is a queue of samples since the last sync.
    logic [WIDTH-1:0] cur[$];
    bit               m_locked = 1'b0;
    logic [WIDTH-1:0] e_a = '0, e_b = '0, e_c = '0, e_d = '0;
    bit               e_ov = 1'b0, e_err = 1'b0;
    int               e_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cur.delete();
            m_locked = 1'b0;
            e_a = '0; e_b = '0; e_c = '0; e_d = '0;
            e_ov = 1'b0; e_err = 1'b0; e_cnt = 0;
        end else begin
            e_ov  = 1'b0;
            e_err = 1'b0;
            if (din_valid) begin
                if (frame_sync) begin
                    if (m_locked && cur.size() != 0) e_err = 1'b1;
                    cur.delete();
                    cur.push_back(din);
                    m_locked = 1'b1;
                end else if (m_locked) begin
                    if (cur.size() == 0) begin
                        e_err    = 1'b1;
                        m_locked = 1'b0;
                    end else begin
                        cur.push_back(din);
                        if (cur.size() == 4) begin
                            e_a = cur[0]; e_b = cur[1]; e_c = cur[2]; e_d = cur[3];
                            e_ov  = 1'b1;
                            e_cnt = (e_cnt + 1) % (1 << CNT_WIDTH);
                            cur.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("m_a", 32'(a), 32'(e_a));
            check("m_b", 32'(b), 32'(e_b));
            check("m_c", 32'(c), 32'(e_c));
            check("m_d", 32'(d), 32'(e_d));
            check("m_out_valid", 32'(out_valid), 32'(e_ov));
            check("m_frame_err", 32'(frame_err), 32'(e_err));
            check("m_frame_cnt", 32'(frame_cnt), 32'(e_cnt));
            check("m_sel", 32'(sel), 32'(cur.size()));
            check("m_locked", 32'(locked), 32'(m_locked));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] v, input logic s);
        din        = v;
        frame_sync = s;
        din_valid  = 1'b1;
        tick();
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                              input logic [WIDTH-1:0] v2, input logic [WIDTH-1:0] v3);
        send(v0, 1'b1);
        send(v1, 1'b0);
        send(v2, 1'b0);
        send(v3, 1'b0);
    endtask

    initial begin
        int fi;
        idle(2);
        #2 reset = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);

        // Normal frame 1,0,1,1
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        check("nf_a", 32'(a), 32'd1);
        check("nf_b", 32'(b), 32'd0);
        check("nf_c", 32'(c), 32'd1);
        check("nf_d", 32'(d), 32'd1);
        check("nf_out_valid", 32'(out_valid), 32'd1);
        check("nf_cnt", 32'(frame_cnt), 32'd1);
        tick();
        check("nf_out_valid_clear", 32'(out_valid), 32'd0);

        // Same frame with 3-cycle stalls
        send(1'b1, 1'b1); idle(3);
        check("stall_sel1", 32'(sel), 32'd1);
        send(1'b0, 1'b0); idle(3);
        send(1'b1, 1'b0); idle(3);
        check("stall_sel3", 32'(sel), 32'd3);
        check("stall_no_ov", 32'(out_valid), 32'd0);
        send(1'b1, 1'b0);
        check("stall_ov", 32'(out_valid), 32'd1);
        check("stall_cnt", 32'(frame_cnt), 32'd2);

        // Early sync
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b1);
        check("es_err", 32'(frame_err), 32'd1);
        check("es_sel", 32'(sel), 32'd1);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        check("es_a", 32'(a), 32'd0);
        check("es_b", 32'(b), 32'd1);
        check("es_c", 32'(c), 32'd1);
        check("es_d", 32'(d), 32'd1);
        check("es_cnt", 32'(frame_cnt), 32'd3);

        // Lost sync after a full frame
        send(1'b1, 1'b0);
        check("ls_err", 32'(frame_err), 32'd1);
        check("ls_locked", 32'(locked), 32'd0);
        send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
        check("ls_ignored_sel", 32'(sel), 32'd0);
        check("ls_ignored_locked", 32'(locked), 32'd0);
        send(1'b1, 1'b1);
        check("ls_relock", 32'(locked), 32'd1);

        // Asynchronous reset mid-frame
        send(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("ar_a", 32'(a), 32'd0);
        check("ar_d", 32'(d), 32'd0);
        check("ar_sel", 32'(sel), 32'd0);
        check("ar_locked", 32'(locked), 32'd0);
        check("ar_cnt", 32'(frame_cnt), 32'd0);
        idle(2);
        #2 reset = 1'b0;
        tick();

        // Exhaustive sweep
        for (int i = 0; i < 64; i++) begin
            fi = i;
            send_frame(fi[5], fi[4], fi[3], fi[2]);
            if ({a, b, c, d} !== {fi[5], fi[4], fi[3], fi[2]}) begin
                check("sweep_abcd", 32'({a, b, c, d}), 32'({fi[5], fi[4], fi[3], fi[2]}));
            end else begin
                n_cmp++;
            end
        end
        check("sweep_cnt", 32'(frame_cnt), 32'd64);

        // Counter wrap: 64 + 200 = 264 -> 8
        for (int i = 0; i < 200; i++) begin
            send_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("wrap_cnt", 32'(frame_cnt), 32'd8);

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            din        = WIDTH'($urandom);
            din_valid  = ($urandom_range(0, 3) != 0);
            frame_sync = ($urandom_range(0, 4) == 0);
            tick();
        end
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Sequential inverse of the team's 4:1 multiplexer: takes one time-division-multiplexed sample stream and splits it back into four channels a, b, c, d.
- Samples arrive one per valid cycle in slot order 0..3 (a, b, c, d), with frame_sync marking slot 0.
- A complete frame is double-buffered and presented on all four outputs at once, with a one-cycle out_valid strobe.
- Sits at the receive end of any link fed by the multiplexer driven with a rotating sel.

Parameters:
- WIDTH, 1, bit width of din and of each channel output.
- CNT_WIDTH, 8, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  TDM sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualifies the current valid sample as slot 0; ignored when din_valid=0.
- a  output  WIDTH  channel 0 (slot 0) of the last complete frame.
- b  output  WIDTH  channel 1 (slot 1) of the last complete frame.
- c  output  WIDTH  channel 2 (slot 2) of the last complete frame.
- d  output  WIDTH  channel 3 (slot 3) of the last complete frame.
- out_valid  output  1  one-cycle strobe: a..d just updated.
- sel  output  2  slot index the next valid sample will fill.
- locked  output  1  high while the FSM is in RUN.
- frame_err  output  1  one-cycle strobe: sync misalignment detected.
- frame_cnt  output  CNT_WIDTH  count of completed frames, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, any time, including mid-frame):
  - a=b=c=d=0, out_valid=0, frame_err=0, sel=0, locked=0, frame_cnt=0.
  - Capture buffer cleared; FSM forced to IDLE.
- FSM states:
  - IDLE: valid samples without frame_sync are discarded and sel stays 0. A valid sample with frame_sync is written to capture slot 0; sel becomes 1; go to RUN.
  - RUN: each valid sample is written to capture slot sel, then sel increments modulo 4. Cycles with din_valid=0 are stalls: no state change, buffer held.
- Frame completion:
  - The edge that accepts the slot-3 sample loads a..d from capture slots 0..2 plus the incoming din (direct bypass for d).
  - The same edge sets out_valid=1 and increments frame_cnt; out_valid clears on the next edge.
  - Latency: outputs are valid in the cycle immediately after the slot-3 sample.
  - a..d hold their values until the next completed frame.
- Sync checking in RUN:
  - frame_sync on a valid sample with sel=0: normal, accepted as slot 0.
  - frame_sync on a valid sample with sel≠0: the partial frame is discarded (outputs untouched, frame_cnt unchanged). frame_err pulses for one cycle. That sample is taken as a new slot 0 and sel becomes 1; FSM stays in RUN.
  - Valid sample at sel=0 without frame_sync: lost alignment. frame_err pulses, sample discarded, FSM returns to IDLE, sel=0.
- Simultaneous events:
  - frame_sync without din_valid has no effect in any state.
  - Slot-3 completion and frame_err cannot coincide, because slot 3 never carries a sync.
- Wrap-around: frame_cnt rolls over from 2^CNT_WIDTH-1 to 0 with no flag.
- Registers: all outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-frame: after 2 samples of a frame, pulse reset → a..d=0, sel=0, locked=0, frame_cnt=0 immediately (asynchronous, before the next edge).
- Normal frame, WIDTH=1: sync+1, then 0, 1, 1 on consecutive cycles → next cycle a=1, b=0, c=1, d=1, out_valid=1 for exactly one cycle, frame_cnt=1.
- Stalls: same frame with din_valid=0 gaps of 3 cycles between samples → identical outputs; out_valid fires only after the 4th valid sample; sel holds during gaps.
- Early sync: sync+1, 0, then sync+0, 1, 1, 1 → frame_err pulse on the 3rd sample; no out_valid for the partial frame; then a=0, b=1, c=1, d=1, frame_cnt=1.
- Lost sync: after a full frame, a valid sample without sync at sel=0 → frame_err pulse, locked=0; further non-sync samples are ignored until a sync sample arrives.
- Exhaustive sweep mirroring the multiplexer bench: for i=0..63, send frame {i[5], i[4], i[3], i[2]} → a..d match bit for bit, zero mismatches, frame_cnt=64 mod 256 = 64.
